// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the instruction-fetch stage.
package mips_pkg;

    localparam int          IF_ADDR_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;   // sll $0,$0,0

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0]          instr;
        logic [IF_ADDR_W-1:0] pc_plus_4;
        logic                 valid;
    } ifid_t;

    // Force an address onto a word boundary.
    function automatic logic [IF_ADDR_W-1:0] word_align(input logic [IF_ADDR_W-1:0] addr);
        return addr & {{(IF_ADDR_W-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_skid_buf.sv
// if_skid_buf: one-entry holding buffer for a fetched IF/ID word that
// arrives while the decode stage is stalled.
module if_skid_buf
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr,
    input  ifid_t wr_data,
    input  logic  rd,
    input  logic  clear,
    output ifid_t rd_data,
    output logic  full
);

    ifid_t data_r;
    logic  full_r;

    // Single entry: clear wins, then a write fills it, then a read empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            full_r <= 1'b0;
        end else if (clear) begin
            full_r <= 1'b0;
        end else if (wr) begin
            data_r <= wr_data;
            full_r <= 1'b1;
        end else if (rd) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign rd_data = data_r;
    assign full    = full_r;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: issues one instruction-memory read per PC over a req/ack
// handshake, loads the IF/ID register, holds the PC through fetch_busy,
// absorbs ID stalls in a one-entry skid buffer and discards wrong-path
// fetches on flush.
// Optional macro IF_PERF_CNT_EN adds fetch-stall and flush cycle counters.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cur_pc,
    input  logic [ADDR_W-1:0] pc_plus_4,
    input  logic              id_stall,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              fetch_busy,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_plus_4,
    output logic              ifid_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    if_state_e         state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] tag_r;
    logic [31:0]       ifid_instr_r;
    logic [ADDR_W-1:0] ifid_pc4_r;
    logic              ifid_valid_r;

    logic              idle_req_s;
    logic              req_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] tag_s;
    logic              complete_s;
    logic              busy_s;
    logic              skid_wr_s;
    logic              skid_rd_s;
    logic              skid_full_s;
    ifid_t             fetch_word_s;
    ifid_t             skid_data_s;

    // Request, completion and skid control. An IDLE request is presented in
    // the same cycle the PC is valid so zero-wait memory sustains 1/cycle;
    // while in reset nothing is requested.
    always_comb begin
        idle_req_s = rst_n & (state_r == IDLE) & ~flush & ~skid_full_s;
        req_s      = idle_req_s | (state_r == WAIT) | (state_r == DROP);
        if (idle_req_s) begin
            addr_s = word_align(cur_pc);
            tag_s  = pc_plus_4;
        end else begin
            addr_s = addr_r;
            tag_s  = tag_r;
        end
        complete_s   = imem_ack & ~flush & (idle_req_s | (state_r == WAIT));
        fetch_word_s = '{instr: imem_rdata, pc_plus_4: tag_s, valid: 1'b1};
        skid_wr_s    = complete_s & id_stall;
        skid_rd_s    = skid_full_s & ~id_stall & ~flush;
        busy_s       = (req_s & ~imem_ack) | skid_full_s | (state_r == DROP);
    end

    // Fetch FSM: one outstanding request; a flushed request is drained in DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            tag_r   <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (idle_req_s) begin
                        addr_r  <= addr_s;
                        tag_r   <= tag_s;
                        state_r <= imem_ack ? IDLE : WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state_r <= IDLE;
                    end else if (flush) begin
                        state_r <= DROP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DROP: begin
                    state_r <= imem_ack ? IDLE : DROP;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // IF/ID register: flush clears, fresh data or skid drain loads, stall
    // holds, otherwise a bubble is inserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_r <= NOP_INSTR;
            ifid_pc4_r   <= {ADDR_W{1'b0}};
            ifid_valid_r <= 1'b0;
        end else if (flush) begin
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
        end else if (complete_s && !id_stall) begin
            ifid_instr_r <= fetch_word_s.instr;
            ifid_pc4_r   <= fetch_word_s.pc_plus_4;
            ifid_valid_r <= fetch_word_s.valid;
        end else if (skid_rd_s) begin
            ifid_instr_r <= skid_data_s.instr;
            ifid_pc4_r   <= skid_data_s.pc_plus_4;
            ifid_valid_r <= skid_data_s.valid;
        end else if (id_stall) begin
            ifid_instr_r <= ifid_instr_r;
            ifid_valid_r <= ifid_valid_r;
        end else begin
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
        end
    end

    if_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (skid_wr_s),
        .wr_data (fetch_word_s),
        .rd      (skid_rd_s),
        .clear   (flush),
        .rd_data (skid_data_s),
        .full    (skid_full_s)
    );

    assign imem_req       = req_s;
    assign imem_addr      = addr_s;
    assign fetch_busy     = busy_s;
    assign ifid_instr     = ifid_instr_r;
    assign ifid_pc_plus_4 = ifid_pc4_r;
    assign ifid_valid     = ifid_valid_r;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Cycle counters for fetch_busy and flush; both wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= busy_s ? (stall_cnt_r + 32'd1) : stall_cnt_r;
            flush_cnt_r <= flush  ? (flush_cnt_r + 32'd1) : flush_cnt_r;
        end
    end

    assign perf_fetch_stall_cnt = stall_cnt_r;
    assign perf_flush_cnt       = flush_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus a randomized run checked
// against an in-order fetch-stream model. Memory latency is programmable.
module tb_if_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cur_pc, pc_plus_4;
    logic        id_stall, flush;
    logic        imem_req, imem_ack, fetch_busy, ifid_valid;
    logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc_plus_4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_stall_cnt, perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign pc_plus_4 = cur_pc + 32'd4;

    // Memory contents: fixed pattern, one special word at 0x20.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    // Memory model: ack in the lat-th cycle of a request (lat=1 is zero-wait).
    int lat_cfg;
    bit rand_lat;
    int lat_rand;
    int wait_cnt;
    int lat_now;
    assign lat_now    = rand_lat ? lat_rand : lat_cfg;
    assign imem_ack   = imem_req && (wait_cnt >= lat_now - 1);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            lat_rand <= 1;
        end else if (imem_req && imem_ack) begin
            wait_cnt <= 0;
            lat_rand <= int'($urandom_range(4, 1));
        end else if (imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cur_pc         (cur_pc),
        .pc_plus_4      (pc_plus_4),
        .id_stall       (id_stall),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .fetch_busy     (fetch_busy),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus_4 (ifid_pc_plus_4),
        .ifid_valid     (ifid_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_stall_cnt (perf_fetch_stall_cnt),
        .perf_flush_cnt       (perf_flush_cnt)
`endif
    );

    task automatic do_reset(input logic [31:0] pc, input int lat);
        rst_n = 1'b0; flush = 1'b0; id_stall = 1'b0; rand_lat = 1'b0;
        cur_pc = pc; lat_cfg = lat;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; id_stall = 1'b0; rand_lat = 1'b0;
        cur_pc = 32'h0000_1234; lat_cfg = 1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", fetch_busy); end
        @(negedge clk); @(negedge clk);
        n_checks++; if (ifid_instr !== NOP_INSTR) begin n_fail++; $display("FAIL reset_instr: got %h want %h", ifid_instr, NOP_INSTR); end
        n_checks++; if (ifid_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", ifid_pc_plus_4); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", ifid_valid); end
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_fetch_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetch_stall_cnt, perf_flush_cnt); end
`endif
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset(32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            a = 32'(i) * 32'd4;
            n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy[%0d]: got %0b want 0", i, fetch_busy); end
            n_checks++; if ({imem_req, imem_addr} !== {1'b1, a}) begin n_fail++; $display("FAIL zw_req[%0d]: got %0b/%h want 1/%h", i, imem_req, imem_addr, a); end
            @(negedge clk);
            n_checks++;
            if ({ifid_instr, ifid_pc_plus_4, ifid_valid} !== {mem_word(a), a + 32'd4, 1'b1}) begin
                n_fail++; $display("FAIL zw_ifid[%0d]: got %h/%h/%0b want %h/%h/1", i, ifid_instr, ifid_pc_plus_4, ifid_valid, mem_word(a), a + 32'd4);
            end
            cur_pc = a + 32'd4;
            #1;
        end
    endtask

    task automatic test_latency();
        do_reset(32'h10, 3);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL lat_addr[%0d]: got %0b/%h want 1/10", c, imem_req, imem_addr); end
            n_checks++; if (fetch_busy !== (c < 2)) begin n_fail++; $display("FAIL lat_busy[%0d]: got %0b want %0b", c, fetch_busy, c < 2); end
            @(negedge clk);
            if (c < 2) begin
                n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early[%0d]: got %0b want 0", c, ifid_valid); end
            end
        end
        n_checks++;
        if ({ifid_instr, ifid_pc_plus_4, ifid_valid} !== {mem_word(32'h10), 32'h14, 1'b1}) begin
            n_fail++; $display("FAIL lat_ifid: got %h/%h/%0b want %h/14/1", ifid_instr, ifid_pc_plus_4, ifid_valid, mem_word(32'h10));
        end
    endtask

    task automatic test_skid();
        do_reset(32'h1C, 1);
        @(negedge clk);
        n_checks++; if ({ifid_pc_plus_4, ifid_valid} !== {32'h20, 1'b1}) begin n_fail++; $display("FAIL skid_first: got %h/%0b want 20/1", ifid_pc_plus_4, ifid_valid); end
        cur_pc = 32'h20; id_stall = 1'b1;
        #1;
        n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL skid_busy0: got %0b want 0", fetch_busy); end
        @(negedge clk);
        cur_pc = 32'h24;
        #1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if ({ifid_instr, ifid_pc_plus_4, ifid_valid} !== {mem_word(32'h1C), 32'h20, 1'b1}) begin
                n_fail++; $display("FAIL skid_hold[%0d]: got %h/%h/%0b want %h/20/1", c, ifid_instr, ifid_pc_plus_4, ifid_valid, mem_word(32'h1C));
            end
            n_checks++; if ({fetch_busy, imem_req} !== 2'b10) begin n_fail++; $display("FAIL skid_full[%0d]: got busy %0b req %0b want 1 0", c, fetch_busy, imem_req); end
            if (c == 1) id_stall = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if ({ifid_instr, ifid_pc_plus_4, ifid_valid} !== {32'hDEAD_BEEF, 32'h24, 1'b1}) begin
            n_fail++; $display("FAIL skid_drain: got %h/%h/%0b want deadbeef/24/1", ifid_instr, ifid_pc_plus_4, ifid_valid);
        end
        n_checks++; if ({fetch_busy, imem_addr} !== {1'b0, 32'h24}) begin n_fail++; $display("FAIL skid_next: got %0b/%h want 0/24", fetch_busy, imem_addr); end
    endtask

    task automatic test_flush_wait();
`ifdef IF_PERF_CNT_EN
        logic [31:0] fb;
`endif
        do_reset(32'h3C, 1);
        @(negedge clk);
        cur_pc = 32'h40; lat_cfg = 3; id_stall = 1'b1;
        #1;
        @(negedge clk);
        n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL fw_pre: got %0b want 1", ifid_valid); end
`ifdef IF_PERF_CNT_EN
        fb = perf_flush_cnt;
`endif
        flush = 1'b1; cur_pc = 32'h80;
        #1;
        n_checks++; if ({fetch_busy, imem_addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL fw_flushcyc: got %0b/%h want 1/40", fetch_busy, imem_addr); end
        @(negedge clk);
        flush = 1'b0; id_stall = 1'b0;
        #1;
        n_checks++; if ({ifid_instr, ifid_valid} !== {NOP_INSTR, 1'b0}) begin n_fail++; $display("FAIL fw_clear: got %h/%0b want %h/0", ifid_instr, ifid_valid, NOP_INSTR); end
        n_checks++; if ({fetch_busy, imem_req, imem_addr} !== {2'b11, 32'h40}) begin n_fail++; $display("FAIL fw_drop: got %0b/%0b/%h want 1/1/40", fetch_busy, imem_req, imem_addr); end
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_flush_cnt !== fb + 32'd1) begin n_fail++; $display("FAIL fw_perf: got %0d want %0d", perf_flush_cnt, fb + 32'd1); end
`endif
        @(negedge clk);
        n_checks++; if ({ifid_instr, ifid_valid} !== {NOP_INSTR, 1'b0}) begin n_fail++; $display("FAIL fw_discard: got %h/%0b want %h/0", ifid_instr, ifid_valid, NOP_INSTR); end
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin n_fail++; $display("FAIL fw_newaddr: got %0b/%h want 1/80", imem_req, imem_addr); end
    endtask

    task automatic test_flush_ack();
        do_reset(32'h50, 2);
        n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL fa_busy: got %0b want 1", fetch_busy); end
        @(negedge clk);
        flush = 1'b1; cur_pc = 32'h90;
        #1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if ({ifid_instr, ifid_valid} !== {NOP_INSTR, 1'b0}) begin n_fail++; $display("FAIL fa_discard: got %h/%0b want %h/0", ifid_instr, ifid_valid, NOP_INSTR); end
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h90}) begin n_fail++; $display("FAIL fa_idle: got %0b/%h want 1/90", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(32'h5C, 1);
        @(negedge clk);
        cur_pc = 32'h60; lat_cfg = 4; id_stall = 1'b1;
        #1;
        @(negedge clk);
        n_checks++; if ({imem_req, ifid_valid} !== 2'b11) begin n_fail++; $display("FAIL rw_pre: got req %0b valid %0b want 1 1", imem_req, ifid_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr, fetch_busy, ifid_instr, ifid_pc_plus_4, ifid_valid} !== {1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL rw_async: got req %0b addr %h busy %0b instr %h pc4 %h valid %0b want all reset", imem_req, imem_addr, fetch_busy, ifid_instr, ifid_pc_plus_4, ifid_valid);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_fetch_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL rw_perf: got %0d/%0d want 0/0", perf_fetch_stall_cnt, perf_flush_cnt); end
`endif
        @(negedge clk);
    endtask

    // Random latency and stalls: IF/ID must present B, B+4, B+8 ... in order,
    // each once, hold under stall and bubble otherwise.
    task automatic test_random();
        logic [31:0] base, exp_pc;
        logic [31:0] s_instr, s_pc4;
        logic        s_valid, s_stall, adv;
        int          k, exp_busy;
        base = 32'h100; k = 0; exp_busy = 0; adv = 1'b0;
        do_reset(base, 1);
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i != 0) begin
                if (adv) cur_pc = cur_pc + 32'd4;
                id_stall = ($urandom_range(99, 0) < 30);
                #1;
            end
            s_instr = ifid_instr; s_pc4 = ifid_pc_plus_4; s_valid = ifid_valid; s_stall = id_stall;
            adv = !fetch_busy;
            if (fetch_busy) exp_busy++;
            if (imem_req) begin
                n_checks++; if (imem_addr !== cur_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, cur_pc); end
            end
            @(negedge clk);
            n_checks++;
            if (s_stall) begin
                if ({ifid_instr, ifid_pc_plus_4, ifid_valid} !== {s_instr, s_pc4, s_valid}) begin
                    n_fail++; $display("FAIL rnd_hold[%0d]: got %h/%h/%0b want %h/%h/%0b", i, ifid_instr, ifid_pc_plus_4, ifid_valid, s_instr, s_pc4, s_valid);
                end
            end else if (ifid_valid) begin
                exp_pc = base + 32'(k) * 32'd4;
                if ({ifid_instr, ifid_pc_plus_4} !== {mem_word(exp_pc), exp_pc + 32'd4}) begin
                    n_fail++; $display("FAIL rnd_order[%0d]: got %h/%h want %h/%h", i, ifid_instr, ifid_pc_plus_4, mem_word(exp_pc), exp_pc + 32'd4);
                end
                k++;
            end else begin
                if (ifid_instr !== NOP_INSTR) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %h want %h", i, ifid_instr, NOP_INSTR); end
            end
        end
        n_checks++; if (k < 40) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want at least 40", k); end
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_fetch_stall_cnt !== 32'(exp_busy)) begin n_fail++; $display("FAIL rnd_perf_stall: got %0d want %0d", perf_fetch_stall_cnt, exp_busy); end
        n_checks++; if (perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL rnd_perf_flush: got %0d want 0", perf_flush_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_skid();
        test_flush_wait();
        test_flush_ack();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
